// File: rtl/local_inject_ctrl_pkg.sv
// Helpers shared by the local injection controller and its FIFO.
// No ports; provides width functions used to size pointers and counters.
package local_inject_ctrl_pkg;

  // Bits needed to index n entries; at least 1 so a single entry still has a
  // legal vector.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold the values 0..maxVal inclusive.
  function automatic int cntWidth(input int maxVal);
    return (maxVal > 0) ? $clog2(maxVal + 1) : 1;
  endfunction

endpackage

// File: rtl/global.vh
// Shared project-wide constants.
//   NUM_CHANNEL : number of router output channels
//   FLIT_WIDTH  : flit width in bits
`ifndef GLOBAL_VH
`define GLOBAL_VH
`define NUM_CHANNEL 5
`define FLIT_WIDTH 64
`endif

// File: rtl/local_inject_ctrl_inject_fifo.sv
// inject_fifo: local injection buffer, FIFO order, no write-to-read bypass.
// Storage is an array with a registered read port; the read register is
// loaded with the entry that will be at the head after this edge, with the
// incoming flit forwarded when it lands on that slot.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-low; empties the FIFO (storage not cleared)
//   push  - write din (ignored while full)
//   pop   - drop the head (ignored while empty)
//   din   - flit to write
//   dout  - current head flit, valid while !empty
//   full  - occupancy == DEPTH (registered)
//   empty - occupancy == 0 (registered)
module inject_fifo
  import local_inject_ctrl_pkg::*;
#(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [FLIT_W-1:0] din,
  output logic [FLIT_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = idxWidth(DEPTH);
  localparam int CNT_W = cntWidth(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [FLIT_W-1:0] doutReg;
  logic [PTR_W-1:0]  wrPtrReg, rdPtrReg, wrPtrNext, rdPtrNext, rdAddr;
  logic [CNT_W-1:0]  countReg, countNext;
  logic              doPush, doPop;

  assign full   = (countReg == DEPTH_C);
  assign empty  = (countReg == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = doutReg;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wrPtrNext = doPush ? wrPtrReg + PTR_W'(1) : wrPtrReg;
    rdPtrNext = doPop  ? rdPtrReg + PTR_W'(1) : rdPtrReg;
    countNext = countReg;
    case ({doPush, doPop})
      2'b10:   countNext = countReg + CNT_W'(1);
      2'b01:   countNext = countReg - CNT_W'(1);
      default: countNext = countReg;
    endcase
    rdAddr = reset ? rdPtrNext : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      wrPtrReg <= wrPtrNext;
      rdPtrReg <= rdPtrNext;
      countReg <= countNext;
    end
  end

  // Storage and read register carry no reset.
  always_ff @(posedge clk) begin
    if (doPush && reset) begin
      mem[wrPtrReg] <= din;
    end
    // Forward din when it is written to the slot that becomes the head.
    if (doPush && reset && (wrPtrReg == rdAddr)) begin
      doutReg <= din;
    end else begin
      doutReg <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/local_inject_ctrl.sv
// local_inject_ctrl: buffers flits from the local core and injects the FIFO
// head into the first free router output channel, scanning upward from a
// priority pointer with wrap-around. Flags starvation when the head has been
// blocked for STARVE_TH cycles.
// Build option: define INJ_ROTATE_PRIORITY_EN to move the priority pointer
// to the channel after each grant; otherwise channel 0 is always highest.
// Ports:
//   clk              - clock, rising edge
//   reset            - synchronous, active-low
//   validIn          - per-channel busy flags (1 = busy)
//   injValid/injFlit - flit offered by the local core
//   injReady         - FIFO not full (registered occupancy)
//   localInjectGrant - one-hot channel taking the head this cycle, or zero
//   injFlitOut       - FIFO head flit
//   starve           - registered starvation flag
`include "global.vh"

module local_inject_ctrl
  import local_inject_ctrl_pkg::*;
#(
  parameter int NUM_CHANNEL = `NUM_CHANNEL,
  parameter int FLIT_W      = `FLIT_WIDTH,
  parameter int DEPTH       = 4,
  parameter int STARVE_TH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CHANNEL-1:0] validIn,
  input  logic                   injValid,
  input  logic [FLIT_W-1:0]      injFlit,
  output logic                   injReady,
  output logic [NUM_CHANNEL-1:0] localInjectGrant,
  output logic [FLIT_W-1:0]      injFlitOut,
  output logic                   starve
);

  localparam int CH_W  = idxWidth(NUM_CHANNEL);
  localparam int CNT_W = cntWidth(STARVE_TH);
  localparam logic [CH_W:0]      NUM_C  = (CH_W + 1)'(NUM_CHANNEL);
  localparam logic [CH_W-1:0]    LAST_C = CH_W'(NUM_CHANNEL - 1);
  localparam logic [CNT_W-1:0]   TH_C   = CNT_W'(STARVE_TH);

  logic                   fifoFull, fifoEmpty;
  logic [CH_W-1:0]        prioReg;
  logic [CH_W-1:0]        chanIdx [NUM_CHANNEL];
  logic [NUM_CHANNEL-1:0] rotFree;
  logic [CH_W-1:0]        grantIdx;
  logic                   grantFound, grantValid;
  logic [CNT_W-1:0]       starveCntReg, starveCntNext;
  logic                   starveReg;

  inject_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (injValid),
    .pop   (grantValid),
    .din   (injFlit),
    .dout  (injFlitOut),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign injReady = ~fifoFull;

  // Scan position gi maps to channel (prioReg + gi) mod NUM_CHANNEL; the sum
  // never reaches 2*NUM_CHANNEL, so a single conditional subtract wraps it.
  for (genvar gi = 0; gi < NUM_CHANNEL; gi++) begin : gScan
    localparam logic [CH_W:0] OFFSET = (CH_W + 1)'(gi);
    logic [CH_W:0] sum;
    assign sum          = {1'b0, prioReg} + OFFSET;
    assign chanIdx[gi]  = (sum >= NUM_C) ? CH_W'(sum - NUM_C) : sum[CH_W-1:0];
    assign rotFree[gi]  = ~validIn[chanIdx[gi]];
  end

  // Walk down so the lowest free scan position is the last one written.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = NUM_CHANNEL - 1; k >= 0; k--) begin
      if (rotFree[k]) begin
        grantFound = 1'b1;
        grantIdx   = chanIdx[k];
      end
    end
  end

  assign grantValid       = grantFound & ~fifoEmpty;
  assign localInjectGrant = grantValid ? (NUM_CHANNEL'(1) << grantIdx) : '0;

  always_comb begin
    if (fifoEmpty || grantValid) begin
      starveCntNext = '0;
    end else if (starveCntReg == TH_C) begin
      starveCntNext = starveCntReg;
    end else begin
      starveCntNext = starveCntReg + CNT_W'(1);
    end
  end

  assign starve = starveReg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      starveCntReg <= '0;
      starveReg    <= 1'b0;
      prioReg      <= '0;
    end else begin
      starveCntReg <= starveCntNext;
      starveReg    <= (starveCntNext == TH_C);
`ifdef INJ_ROTATE_PRIORITY_EN
      if (grantValid) begin
        prioReg <= (grantIdx == LAST_C) ? '0 : grantIdx + CH_W'(1);
      end
`else
      prioReg <= '0;
`endif
    end
  end

endmodule

// File: doc/local_inject_ctrl.md
LOCAL_INJECT_CTRL -- requirements
Module: local_inject_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHANNEL, default `NUM_CHANNEL (5): number of router output channels scanned for a free slot.
REQ-002 SHALL have parameter FLIT_W, default 64: injected flit width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, power of two >= 2: local injection FIFO depth in flits.
REQ-004 SHALL have parameter STARVE_TH, default 8, range 1..255: starvation threshold in cycles.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port validIn, input, NUM_CHANNEL: per-channel occupancy after eject/kill; 1 = channel busy.
REQ-008 SHALL have port injValid, input, 1: the local core offers injFlit this cycle.
REQ-009 SHALL have port injFlit, input, FLIT_W: flit offered by the local core.
REQ-010 SHALL have port injReady, output, 1: FIFO can accept a flit; a push occurs when injValid & injReady.
REQ-011 SHALL have port localInjectGrant, output, NUM_CHANNEL: one-hot or zero; the channel receiving the FIFO head this cycle.
REQ-012 SHALL have port injFlitOut, output, FLIT_W: FIFO head flit; meaningful only when the grant is non-zero.
REQ-013 SHALL have port starve, output, 1: registered flag meaning the injection has been blocked for at least STARVE_TH cycles.

Function
REQ-014 SHALL store pushed flits in FIFO order; a flit pushed in cycle t SHALL become eligible at the head no earlier than t+1 (no bypass).
REQ-015 SHALL drive injReady = (occupancy < DEPTH), taken from registered occupancy; a pop in the same cycle SHALL NOT raise injReady.
REQ-016 SHALL compute localInjectGrant combinationally in the same cycle from validIn, FIFO non-empty and the priority pointer.
REQ-017 SHALL grant the first channel with validIn = 0, scanning upward from the priority pointer and wrapping modulo NUM_CHANNEL.
REQ-018 SHALL drive an all-zero grant when the FIFO is empty or all validIn bits are 1.
REQ-019 SHALL pop the head on the rising edge that ends every cycle with a non-zero grant; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-020 SHALL keep a saturating starvation counter of width clog2(STARVE_TH+1) bits.
REQ-021 SHALL increment the counter in each cycle where the FIFO is non-empty and the grant is zero.
REQ-022 SHALL clear the counter on any grant and whenever the FIFO is empty.
REQ-023 SHALL register starve = (next counter value == STARVE_TH), so that starve deasserts on the edge after the next grant.
REQ-024 SHALL wrap the FIFO pointers at DEPTH with no overflow or underflow under any input sequence.

Reset
REQ-025 SHALL, when reset = 0 at a clock edge, set occupancy, read and write pointers, starvation counter, starve and the priority pointer to 0.
REQ-026 SHALL discard all buffered flits on reset, including reset asserted mid-operation.
REQ-027 SHALL yield injReady = 1 and localInjectGrant = 0 in the cycle after reset; FIFO data storage is not reset.

Configuration
REQ-028 SHALL, with macro INJ_ROTATE_PRIORITY_EN defined, advance the priority pointer after each grant to (granted index + 1) mod NUM_CHANNEL.
REQ-029 SHALL, without INJ_ROTATE_PRIORITY_EN, hold the priority pointer at 0; the grant then equals lowest-free-channel priority (channel 0 highest).

Structure
REQ-030 SHALL take the NUM_CHANNEL default and the flit-width constant from the shared global.vh include; no local redefinition.
REQ-031 SHALL implement the buffer as sub-module inject_fifo (parameters FLIT_W and DEPTH; ports push, pop, dout, full, empty).
REQ-032 SHALL implement the wrap-around priority scan in the top level as a parameterised loop, with no per-channel hand-written terms.

Verification
REQ-033 Fixed priority, N=5, 1 flit queued, validIn=5'b00011 -> grant=5'b00100, injFlitOut = head, FIFO empty on the next cycle.
REQ-034 Fill test, injValid=1 for 4 cycles with all channels busy -> injReady=0 from cycle 4; a 5th push is not accepted; occupancy = 4.
REQ-035 Starvation, STARVE_TH=8, FIFO non-empty, validIn=all 1s -> starve=1 after the 8th blocked cycle; one free channel -> grant issued, starve=0 on the following cycle.
REQ-036 INJ_ROTATE_PRIORITY_EN, validIn=0, 3 queued flits -> grants 5'b00001, 5'b00010, 5'b00100 on consecutive cycles.
REQ-037 Reset asserted with 3 flits queued and starve=1 -> next cycle: grant=0, injReady=1, starve=0; a new push appears at the head one cycle later.
